// File: rtl/chengfa_div_pkg.sv
// rtl/chengfa_div_pkg.sv - shared state encoding, default width and sign helper for chengfa_div
package chengfa_div_pkg;

  // Default magnitude width; operands and results carry one extra sign bit.
  localparam int DIV_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign bit for a sign-magnitude result: a zero magnitude is always positive.
  function automatic logic sm_sign(input logic s, input logic mag_nz);
    return s & mag_nz;
  endfunction

endpackage

// File: rtl/chengfa_div_step.sv
// rtl/chengfa_div_step.sv - one combinational restoring-division step (module div_step)
import chengfa_div_pkg::*;

module div_step #(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] p,
  input  logic         d,
  input  logic [W-1:0] b,
  output logic [W-1:0] p_next,
  output logic         qbit
);

  logic [W:0] t;

  // Shift the next dividend bit into the partial remainder and subtract |b| if it fits.
  // The remainder stays below |b|, so the low W bits of the difference are exact.
  always_comb begin
    t      = {p, d};
    qbit   = 1'b0;
    p_next = t[W-1:0];
    if (t >= {1'b0, b}) begin
      qbit   = 1'b1;
      p_next = t[W-1:0] - b;
    end
  end

endmodule

// File: rtl/chengfa_div.sv
// rtl/chengfa_div.sv - sequential sign-magnitude restoring divider (option: CHENGFA_DIV_EARLY_EXIT_EN)
import chengfa_div_pkg::*;

module chengfa_div #(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W:0]   a,
  input  logic [W:0]   b,
  output logic         busy,
  output logic         done,
  output logic [W:0]   q,
  output logic [W:0]   r,
  output logic         dz
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  da;      // dividend shifts out MSB first, quotient bits shift in at the LSB
  logic [W-1:0]  db;
  logic [W-1:0]  p;
  logic          sa;
  logic          sb;

  logic [W-1:0]  step_p;
  logic          step_q;
  logic [W-1:0]  q_mag;

  div_step #(.W(W)) u_step (
    .p      (p),
    .d      (da[W-1]),
    .b      (db),
    .p_next (step_p),
    .qbit   (step_q)
  );

  assign q_mag = {da[W-2:0], step_q};

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      da    <= '0;
      db    <= '0;
      p     <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a[W];
            sb   <= b[W];
            da   <= a[W-1:0];
            db   <= b[W-1:0];
            p    <= '0;
            cnt  <= CW'(W - 1);
            busy <= 1'b1;
            if (b[W-1:0] == '0) begin
              state <= DONE;
              done  <= 1'b1;
              dz    <= 1'b1;
              q     <= {sm_sign(a[W] ^ b[W], 1'b1), {W{1'b1}}};
              r     <= {sm_sign(a[W], |a[W-1:0]), a[W-1:0]};
            end
`ifdef CHENGFA_DIV_EARLY_EXIT_EN
            else if (a[W-1:0] < b[W-1:0]) begin
              state <= DONE;
              done  <= 1'b1;
              dz    <= 1'b0;
              q     <= '0;
              r     <= {sm_sign(a[W], |a[W-1:0]), a[W-1:0]};
            end
`endif
            else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= step_p;
          da  <= q_mag;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
            dz    <= 1'b0;
            q     <= {sm_sign(sa ^ sb, |q_mag), q_mag};
            r     <= {sm_sign(sa, |step_p), step_p};
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chengfa_div.sv
// tb/tb_chengfa_div.sv - directed and exhaustive self-checking bench for chengfa_div
module tb_chengfa_div;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       busy;
  logic       done;
  logic [5:0] q;
  logic [5:0] r;
  logic       dz;

  int checks;
  int errors;

  int         lat;
  int         bcnt;
  int         dcnt;
  int         exp_lat;
  logic [5:0] qo;
  logic [5:0] ro;
  logic       dzo;
  logic [4:0] ma;
  logic [4:0] mb;
  logic [4:0] eq;
  logic [4:0] er;
  logic [5:0] exp_q;
  logic [5:0] exp_r;
  logic       exp_dz;

`ifdef CHENGFA_DIV_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  chengfa_div dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one division from an IDLE cycle, scramble the operands once accepted,
  // wait (bounded) for done, capture the result and step into the next cycle.
  task automatic do_div(input logic [5:0] av, input logic [5:0] bv,
                        output int lat_o, output int bcnt_o,
                        output logic [5:0] q_o, output logic [5:0] r_o, output logic dz_o);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    a      = 6'($urandom);
    b      = 6'($urandom);
    lat_o  = 1;
    bcnt_o = int'(busy);
    while (!done && lat_o < 20) begin
      @(negedge clk);
      lat_o++;
      bcnt_o += int'(busy);
    end
    q_o  = q;
    r_o  = r;
    dz_o = dz;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_dz", dz, 0);
    reset = 1'b1;
    @(negedge clk);

    // +23 / +5
    do_div(6'b0_10111, 6'b0_00101, lat, bcnt, qo, ro, dzo);
    check("p23_q", qo, 6'b0_00100);
    check("p23_r", ro, 6'b0_00011);
    check("p23_dz", dzo, 0);
    check("p23_lat", lat, 6);
    check("p23_busy_cycles", bcnt, 6);
    check("p23_done_pulse", done, 0);
    check("p23_busy_after", busy, 0);
    check("p23_q_hold", q, 6'b0_00100);

    // -31 / +4
    do_div(6'b1_11111, 6'b0_00100, lat, bcnt, qo, ro, dzo);
    check("m31_q", qo, 6'b1_00111);
    check("m31_r", ro, 6'b1_00011);
    check("m31_lat", lat, 6);

    // -10 / -0 divide by zero
    do_div(6'b1_01010, 6'b1_00000, lat, bcnt, qo, ro, dzo);
    check("dz_flag", dzo, 1);
    check("dz_q", qo, 6'b0_11111);
    check("dz_r", ro, 6'b1_01010);
    check("dz_lat", lat, 1);

    // +3 / -7, negative zero suppressed
    do_div(6'b0_00011, 6'b1_00111, lat, bcnt, qo, ro, dzo);
    check("small_q", qo, 6'b0_00000);
    check("small_r", ro, 6'b0_00011);
    check("small_dz", dzo, 0);
    check("small_lat", lat, (EARLY != 0) ? 1 : 6);

    // reset mid-CALC with an ignored second start
    a     = 6'b0_10111;
    b     = 6'b0_00101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_done", done, 0);
    dcnt = int'(done);
    repeat (8) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("midrst_no_done", dcnt, 0);
    do_div(6'b0_10111, 6'b0_00101, lat, bcnt, qo, ro, dzo);
    check("after_rst_q", qo, 6'b0_00100);
    check("after_rst_r", ro, 6'b0_00011);
    check("after_rst_lat", lat, 6);

    // exhaustive sweep against a truncating-division model
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        do_div(6'(ai), 6'(bi), lat, bcnt, qo, ro, dzo);
        ma = 5'(ai);
        mb = 5'(bi);
        if (mb == 5'd0) begin
          eq      = 5'd31;
          er      = ma;
          exp_dz  = 1'b1;
          exp_lat = 1;
        end else begin
          eq      = ma / mb;
          er      = ma % mb;
          exp_dz  = 1'b0;
          exp_lat = (EARLY != 0 && ma < mb) ? 1 : 6;
        end
        exp_q = {(ai[5] ^ bi[5]) && (eq != 5'd0), eq};
        exp_r = {ai[5] && (er != 5'd0), er};
        check($sformatf("sweep_res a=%02h b=%02h", ai, bi), {qo, ro, dzo}, {exp_q, exp_r, exp_dz});
        check($sformatf("sweep_lat a=%02h b=%02h", ai, bi), lat, exp_lat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chengfa_div.md
Name: chengfa_div

Overview:
- Sequential sign-magnitude integer divider; the inverse operation of the existing 5x5 sign-magnitude multiplier.
- Operand format matches the multiplier: bit W is the sign, bits W-1:0 are the magnitude.
- Restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Feeds the same LED/switch front end as the multiplier; operands come from the switch-driven A/B inputs.

Parameters:
- W, 5, magnitude width in bits; operands and results are W+1 bits wide.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge; 0 = reset.
- start  in  1  request a division; accepted only in IDLE.
- a  in  W+1  dividend; a[W] is the sign, a[W-1:0] is the magnitude.
- b  in  W+1  divisor; same format as a.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse when q, r and dz are valid.
- q  out  W+1  quotient, sign-magnitude.
- r  out  W+1  remainder, sign-magnitude.
- dz  out  1  divide-by-zero flag; valid with done.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, q=0, r=0, dz=0.
  - Internal registers are cleared.
  - Reset takes priority over every other event, including mid-CALC; any in-flight result is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge latches |a|, |b|, sa=a[W], sb=b[W]. In the same edge: partial remainder P=0, counter=W-1.
  - If |b|=0 -> DONE with dz=1.
  - Otherwise -> CALC.
  - start=0 -> stay in IDLE.
- CALC, one iteration per cycle, MSB first:
  - T = {P, next dividend bit}, W+1 bits wide.
  - If T >= |b|: P = T - |b| and the quotient bit is 1.
  - Else: P = T and the quotient bit is 0.
  - After counter=0 is processed -> DONE.
  - No arithmetic overflow is possible: P < |b| always holds, so W+1 bits suffice.
- DONE, lasting exactly one cycle:
  - done=1.
  - q, r and dz are registered on entry and held until the next completion.
  - Next state is IDLE unconditionally; start is ignored while in DONE.
- busy=1 in CALC and DONE. start while busy is ignored, with no queueing.
- Latency, normal path: start sampled at edge 0, done high in the cycle following edge W+1 (6 cycles for W=5).
- Latency, divide-by-zero: done high in the cycle following edge 1.
- Sign rules:
  - q sign = sa^sb; r sign = sa (truncating division, same as C).
  - Negative zero is suppressed: a zero magnitude always gets sign 0.
- Divide-by-zero result: q magnitude = all ones (31), q sign = sa^sb, r = a unchanged apart from zero-sign suppression, dz=1.
- Operand changes on a/b after start has been accepted have no effect on the running division.

Optional Feature:
- Macro: CHENGFA_DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE on start, if |b| != 0 and |a| < |b|, go straight to DONE with q=0 and r=a (sign-suppressed).
  - done arrives 1 cycle after the start edge.
- Undefined:
  - Every nonzero divisor takes the full W CALC cycles.
  - Results are identical either way; only latency differs.

Decomposition:
- Package chengfa_div_pkg holds:
  - the state enum (IDLE/CALC/DONE);
  - the default width constant DIV_W=5;
  - a helper for sign-magnitude zero suppression.
- Sub-module div_step: one combinational restoring step.
  - Inputs: P, dividend bit, |b|.
  - Outputs: new P, quotient bit.
  - Instantiated once and iterated by the FSM.

Test Plan:
- a=0_10111 (+23), b=0_00101 (+5), start for 1 cycle -> busy for 6 cycles; done pulse at cycle 6 with q=0_00100 (+4), r=0_00011 (+3), dz=0.
- a=1_11111 (-31), b=0_00100 (+4) -> q=1_00111 (-7), r=1_00011 (-3).
- a=1_01010 (-10), b=1_00000 (-0) -> dz=1, q=0_11111, r=1_01010, done 1 cycle after start.
- a=0_00011 (+3), b=1_00111 (-7) -> q=0_00000 (no negative zero), r=0_00011; done at cycle 1 with CHENGFA_DIV_EARLY_EXIT_EN defined, cycle 6 without.
- Start with a=+23, b=+5; pulse start again at cycle 2; drive reset=0 at cycle 3 -> second start ignored; after the reset edge busy=0, q=r=0, no done pulse; a fresh start then completes normally.
- Exhaustive: all 4096 (a,b) pairs issued back to back, each start raised in the first IDLE cycle after done -> every result matches the model. Model: q = sign(sa^sb) trunc(|a|/|b|), r = sign(sa) |a| mod |b|, plus the zero-sign and dz rules above.
